alu_sub_serial: RTL

Sequential 16-bit subtractor producing `z = x - y` and the same five status flags (sign, zero, carry, parity, overflow) as the team's 16-bit adder ALU. It is the inverse-operation companion to that adder. It processes the operands in SLICE-bit slices over several cycles to keep the borrow chain short. Valid/ready handshakes on both sides let it sit between an operand-issue stage and a result/flag-writeback stage.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_sub_slice.sv | 20 ++
 rtl/alu_sub_serial.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: FSM state, status-flag bundle and default datapath width.
// Used by the serial subtractor and reusable by the companion adder.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic parity;
        logic overflow;
    } alu_flags_t;

    // Subtraction overflows when the operand signs differ and the result sign leaves the minuend's.
    function automatic logic alu_sub_ovf(input logic x_msb, input logic y_msb, input logic z_msb);
        return (x_msb != y_msb) && (z_msb != x_msb);
    endfunction

endpackage

// File: rtl/alu_sub_slice.sv
// Combinational SLICE-bit subtract a - b - borrow_in with borrow out; zero latency, no flow control.
// Time-multiplexed by the serial subtractor across operand slices.
module alu_sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             borrow_i,
    output logic [SLICE-1:0] diff_o,
    output logic             borrow_o
);

    logic [SLICE:0] res;

    // One extra bit holds the sign of the slice result, which is exactly the borrow out.
    assign res      = {1'b0, a_i} - {1'b0, b_i} - {{SLICE{1'b0}}, borrow_i};
    assign diff_o   = res[SLICE-1:0];
    assign borrow_o = res[SLICE];

endmodule

// File: rtl/alu_sub_serial.sv
// Serial z = x - y with ALU flags, WIDTH/SLICE cycles accept-to-valid; holds result in DONE until out_ready.
// Optional ALU_SUB_LT_EN adds registered lt_u/lt_s compare outputs.
module alu_sub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
`ifdef ALU_SUB_LT_EN
    ,
    output logic             lt_u,
    output logic             lt_s
`endif
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    alu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    alu_flags_t       flags_q, flags_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_diff;
    logic             sl_borrow;
    logic [WIDTH-1:0] z_full;
    logic             ovf_full;
    int               base;

    assign base = int'(cnt_q) * SLICE;
    assign sl_a = x_q[base +: SLICE];
    assign sl_b = y_q[base +: SLICE];

    alu_sub_slice #(.SLICE(SLICE)) u_slice (
        .a_i      (sl_a),
        .b_i      (sl_b),
        .borrow_i (borrow_q),
        .diff_o   (sl_diff),
        .borrow_o (sl_borrow)
    );

    // z as it will look once the current slice is written; on the last slice this is the final result.
    always_comb begin
        z_full = z_q;
        z_full[base +: SLICE] = sl_diff;
    end

    assign ovf_full = alu_sub_ovf(x_q[WIDTH-1], y_q[WIDTH-1], z_full[WIDTH-1]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = x;
                    y_d      = y;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                z_d      = z_full;
                borrow_d = sl_borrow;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d          = DONE;
                    flags_d.sign     = z_full[WIDTH-1];
                    flags_d.zero     = (z_full == '0);
                    flags_d.carry    = sl_borrow;
                    flags_d.parity   = ~^z_full;
                    flags_d.overflow = ovf_full;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            flags_q  <= flags_d;
        end
    end

`ifdef ALU_SUB_LT_EN
    logic lt_u_q, lt_u_d;
    logic lt_s_q, lt_s_d;

    always_comb begin
        lt_u_d = lt_u_q;
        lt_s_d = lt_s_q;
        if (state_q == RUN && cnt_q == LAST) begin
            lt_u_d = sl_borrow;
            lt_s_d = z_full[WIDTH-1] ^ ovf_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_u_q <= 1'b0;
            lt_s_q <= 1'b0;
        end else begin
            lt_u_q <= lt_u_d;
            lt_s_q <= lt_s_d;
        end
    end

    assign lt_u = lt_u_q;
    assign lt_s = lt_s_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = z_q;
    assign sign      = flags_q.sign;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign parity    = flags_q.parity;
    assign overflow  = flags_q.overflow;

endmodule
